alu_datapath: RTL and testbench
===============================

// Module: alu_datapath
// PURPOSE
//  Execute-side responder to the instruction controller. Takes the controller's
//  enable/opcode/a/b command and runs ADD/SUB in one cycle and MUL/DIV iteratively.
//  Reports completion to the controller on done, with a four-phase handshake.
//  Sits between the controller and the result/register write-back logic.
// PARAMETERS
//  WIDTH   16  result width; must equal 2*OPW
//  OPW     8   operand width of a and b
// PORTS
//  clk            in   1      single clock; all state updates on posedge
//  reset          in   1      asynchronous, active-low reset (0 = reset)
//  enable         in   1      command valid from controller; level, held until done seen
//  opcode         in   4      0 ADD, 1 SUB, 2 MUL, 3 DIV, 4..15 invalid
//  a              in   OPW    operand A (unsigned)
//  b              in   OPW    operand B (unsigned)
//  done           out  1      completion; high in DONE until enable drops
//  busy           out  1      high in CALC
//  result         out  WIDTH  last completed result; holds between commands
//  zero           out  1      result==0 for the last completed command
//  carry          out  1      ADD carry-out of bit OPW / SUB borrow (a<b); 0 otherwise
//  err            out  1      divide-by-zero or invalid opcode on last command
// BEHAVIOUR
//  Reset (reset=0, any time, async): state=IDLE; done=busy=zero=carry=err=0; result=0;
//   iteration counter=0. An operation in flight is discarded, with no partial result.
//  FSM IDLE->CALC->DONE->IDLE.
//   IDLE: on posedge with enable=1, latch opcode/a/b, clear counter, go to CALC.
//   CALC: busy=1. Inputs are ignored except enable. If enable=0, abort to IDLE;
//    result and flags are unchanged and done is never raised.
//   DONE: done=1 and outputs stable. Stay while enable=1; go to IDLE on the first
//    cycle enable=0. A new command needs enable low for at least one cycle.
//  Latency (enable sampled at edge N): ADD/SUB/invalid done=1 from edge N+2;
//   MUL/DIV done=1 from edge N+9 (8 iterations, one per cycle in CALC).
//  ADD: result = zext(a)+zext(b); carry = sum[OPW].
//  SUB: result = zext(a)-zext(b) mod 2^WIDTH; carry = (a<b).
//  MUL: shift-add on the latched copies; result = a*b (fits WIDTH, no overflow).
//  DIV: restoring division; result = {quotient[OPW-1:0], remainder[OPW-1:0]}.
//   If b==0: skip iterations, DONE at N+2, result={OPW'hFF, a}, err=1.
//  Invalid opcode (>=4): DONE at N+2, result unchanged, err=1, carry=0.
//  result/zero/carry/err update only on the CALC->DONE transition.
//  Simultaneous events: abort (enable=0) in the final CALC cycle wins, so no
//   update occurs. The controller drops enable one cycle after done, which is legal.
// STRUCTURE
//  Package alu_pkg: opcode_e enum {OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3};
//   state_e {S_IDLE, S_CALC, S_DONE}; localparam ITER=8; localparam OPCODE_W=4.
//  Sub-module shift_muldiv: the 8-step MUL/DIV engine. Ports: start, is_div, a, b,
//   abort, out, valid. The top module holds the FSM, the 1-cycle ALU and the flags.
// TESTING
//  1 ADD a=8'hF0 b=8'h20, enable held -> done at N+2, result=16'h0110, carry=1, err=0.
//  2 SUB a=3 b=5 -> result=16'hFFFE, carry=1. MUL a=8'hFF b=8'hFF -> done at N+9,
//    result=16'hFE01. DIV a=100 b=7 -> result=16'h0E02.
//  3 DIV a=42 b=0 -> done at N+2, result=16'hFF2A, err=1. Opcode 4'hF -> err=1,
//    result unchanged.
//  4 MUL started, enable dropped at N+4 -> IDLE, done never high, result unchanged.
//    Next command completes normally.
//  5 reset pulsed low during CALC of DIV -> all outputs 0 immediately (async).
//    After release, ADD 1+1 -> result=2.
//  6 enable held 5 cycles after done -> done stays 1 and result stable. Drop enable
//    -> done=0 next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU datapath.
package alu_pkg;

    localparam int ITER     = 8;   // MUL/DIV iterations, one per CALC cycle
    localparam int OPCODE_W = 4;

    typedef enum logic [OPCODE_W-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_DIV = 4'd3
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_e;

endpackage

// File: rtl/alu_datapath_shift_muldiv.sv
// Iterative engine: shift-add multiply or restoring divide, one bit per cycle.
// Loads its own copy of the operands on start; valid rises after the last step
// and stays until the next start or abort.
module shift_muldiv
    import alu_pkg::*;
#(
    parameter int OPW   = 8,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    input  logic [OPW-1:0]   a,
    input  logic [OPW-1:0]   b,
    input  logic             abort,
    output logic [WIDTH-1:0] out,
    output logic             valid
);

    localparam int STEP_W = $clog2(ITER);

    logic              run;
    logic              is_div_q;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  acc;      // MUL accumulator
    logic [WIDTH-1:0]  mcand;    // MUL multiplicand, shifted left each step
    logic [OPW-1:0]    mplier;   // MUL multiplier / DIV dividend-then-quotient
    logic [OPW-1:0]    rem;      // DIV partial remainder
    logic [OPW-1:0]    divisor;

    // Restoring-divide step: bring the next dividend bit into the remainder.
    logic [OPW:0]   shifted;
    logic           ge;
    logic [OPW-1:0] diff;

    assign shifted = {rem, mplier[OPW-1]};
    assign ge      = shifted >= {1'b0, divisor};
    assign diff    = shifted[OPW-1:0] - divisor;   // only used when ge, so fits OPW

    assign out = is_div_q ? {mplier, rem} : acc;

    // Load on start, iterate while running, drop everything on abort.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run      <= 1'b0;
            valid    <= 1'b0;
            is_div_q <= 1'b0;
            step     <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            rem      <= '0;
            divisor  <= '0;
        end else if (abort) begin
            run   <= 1'b0;
            valid <= 1'b0;
        end else if (start) begin
            run      <= 1'b1;
            valid    <= 1'b0;
            is_div_q <= is_div;
            step     <= '0;
            acc      <= '0;
            mcand    <= WIDTH'(a);
            mplier   <= is_div ? a : b;
            rem      <= '0;
            divisor  <= b;
        end else if (run) begin
            if (is_div_q) begin
                rem    <= ge ? diff : shifted[OPW-1:0];
                mplier <= {mplier[OPW-2:0], ge};
            end else begin
                if (mplier[0]) acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end
            step <= step + 1'b1;
            if (step == STEP_W'(ITER - 1)) begin
                run   <= 1'b0;
                valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_datapath.sv
// Execute-side responder: IDLE->CALC->DONE handshake with the controller,
// single-cycle ADD/SUB, iterative MUL/DIV via shift_muldiv, result and flags.
module alu_datapath
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OPW   = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [OPW-1:0]      a,
    input  logic [OPW-1:0]      b,
    output logic                done,
    output logic                busy,
    output logic [WIDTH-1:0]    result,
    output logic                zero,
    output logic                carry,
    output logic                err
);

    state_e              state_q, state_d;
    logic [OPCODE_W-1:0] op_q;
    logic [OPW-1:0]      a_q, b_q;
    logic [3:0]          cnt_q;

    logic             take, is_mul, is_div, div0, iterative, fin, update;
    logic             eng_start, eng_abort, eng_valid;
    logic [WIDTH-1:0] eng_out;
    logic [WIDTH-1:0] sum, nxt_result;
    logic             nxt_carry, nxt_err;

    assign take      = (state_q == S_IDLE) && enable;
    assign is_mul    = (op_q == OP_MUL);
    assign is_div    = (op_q == OP_DIV);
    assign div0      = is_div && (b_q == '0);
    assign iterative = (is_mul || is_div) && !div0;
    // Single-cycle ops finish on the second CALC edge, iterative ones when the engine is done.
    assign fin       = iterative ? eng_valid : (cnt_q == 4'd1);
    // Abort wins over completion in the same cycle.
    assign update    = (state_q == S_CALC) && enable && fin;

    assign eng_start = take && ((opcode == OP_MUL) || ((opcode == OP_DIV) && (b != '0)));
    assign eng_abort = (state_q == S_CALC) && !enable;

    assign done = (state_q == S_DONE);
    assign busy = (state_q == S_CALC);

    shift_muldiv #(.OPW(OPW), .WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (eng_start),
        .is_div (opcode == OP_DIV),
        .a      (a),
        .b      (b),
        .abort  (eng_abort),
        .out    (eng_out),
        .valid  (eng_valid)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic for the four-phase handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (enable) state_d = S_CALC;
            S_CALC: begin
                if (!enable)  state_d = S_IDLE;
                else if (fin) state_d = S_DONE;
            end
            S_DONE: if (!enable) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Command latch and CALC cycle counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            cnt_q <= '0;
        end else if (take) begin
            op_q  <= opcode;
            a_q   <= a;
            b_q   <= b;
            cnt_q <= '0;
        end else if (state_q == S_CALC) begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

    // Result and flags for the command now completing.
    always_comb begin
        sum        = WIDTH'(a_q) + WIDTH'(b_q);
        nxt_result = result;
        nxt_carry  = 1'b0;
        nxt_err    = 1'b0;
        case (op_q)
            OP_ADD: begin
                nxt_result = sum;
                nxt_carry  = sum[OPW];
            end
            OP_SUB: begin
                nxt_result = WIDTH'(a_q) - WIDTH'(b_q);
                nxt_carry  = (a_q < b_q);
            end
            OP_MUL: nxt_result = eng_out;
            OP_DIV: begin
                if (div0) begin
                    nxt_result = {{OPW{1'b1}}, a_q};
                    nxt_err    = 1'b1;
                end else begin
                    nxt_result = eng_out;
                end
            end
            default: nxt_err = 1'b1;   // invalid opcode: result kept
        endcase
    end

    // Outputs change only on CALC->DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result <= '0;
            zero   <= 1'b0;
            carry  <= 1'b0;
            err    <= 1'b0;
        end else if (update) begin
            result <= nxt_result;
            zero   <= (nxt_result == '0);
            carry  <= nxt_carry;
            err    <= nxt_err;
        end
    end

endmodule

// File: tb/tb_alu_datapath.sv
// Directed bench for alu_datapath: handshake latency, arithmetic, flags, abort, async reset.
module tb_alu_datapath;

    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, MUL = 4'd2, DIV = 4'd3, BAD = 4'hF;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [3:0]  opcode;
    logic [7:0]  a, b;
    logic        done, busy, zero, carry, err;
    logic [15:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    alu_datapath #(.WIDTH(16), .OPW(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .opcode (opcode),
        .a      (a),
        .b      (b),
        .done   (done),
        .busy   (busy),
        .result (result),
        .zero   (zero),
        .carry  (carry),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue a command, check done is low one edge before the expected latency
    // and high at it, then check the outputs.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] va,
                          input logic [7:0] vb, input int lat, input logic [15:0] exp_res,
                          input logic exp_carry, input logic exp_err);
        opcode = op; a = va; b = vb; enable = 1'b1;
        tick(lat);
        chk({tag, ".done_early"}, 32'(done), 32'd0);
        tick(1);
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".result"}, 32'(result), 32'(exp_res));
        chk({tag, ".carry"}, 32'(carry), 32'(exp_carry));
        chk({tag, ".err"}, 32'(err), 32'(exp_err));
        chk({tag, ".zero"}, 32'(zero), 32'(exp_res == 16'h0000));
    endtask

    task automatic release_op(input string tag);
        enable = 1'b0;
        tick(1);
        chk({tag, ".done_drop"}, 32'(done), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".done"}, 32'(done), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".result"}, 32'(result), 32'd0);
        chk({tag, ".zero"}, 32'(zero), 32'd0);
        chk({tag, ".carry"}, 32'(carry), 32'd0);
        chk({tag, ".err"}, 32'(err), 32'd0);
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; opcode = 4'd0; a = 8'd0; b = 8'd0;
        tick(3);
        chk_all_zero("reset");
        reset = 1'b1;
        tick(2);

        // ADD with carry-out, plus busy/done in the first CALC cycle
        opcode = ADD; a = 8'hF0; b = 8'h20; enable = 1'b1;
        tick(1);
        chk("add.busy", 32'(busy), 32'd1);
        chk("add.done_n", 32'(done), 32'd0);
        tick(1);
        chk("add.done_n1", 32'(done), 32'd0);
        tick(1);
        chk("add.done", 32'(done), 32'd1);
        chk("add.busy_off", 32'(busy), 32'd0);
        chk("add.result", 32'(result), 32'h0110);
        chk("add.carry", 32'(carry), 32'd1);
        chk("add.err", 32'(err), 32'd0);
        release_op("add");

        run_op("sub",    SUB, 8'd3,   8'd5,   2, 16'hFFFE, 1'b1, 1'b0); release_op("sub");
        run_op("mul",    MUL, 8'hFF, 8'hFF, 9, 16'hFE01, 1'b0, 1'b0); release_op("mul");
        run_op("div",    DIV, 8'd100, 8'd7,   9, 16'h0E02, 1'b0, 1'b0); release_op("div");
        run_op("div0",   DIV, 8'd42,  8'd0,   2, 16'hFF2A, 1'b0, 1'b1); release_op("div0");
        run_op("badop",  BAD, 8'd1,   8'd2,   2, 16'hFF2A, 1'b0, 1'b1); release_op("badop");
        run_op("mulz",   MUL, 8'd5,   8'd0,   9, 16'h0000, 1'b0, 1'b0); release_op("mulz");
        run_op("addc",   ADD, 8'hFF, 8'h01, 2, 16'h0100, 1'b1, 1'b0); release_op("addc");
        run_op("subeq",  SUB, 8'd9,   8'd9,   2, 16'h0000, 1'b0, 1'b0); release_op("subeq");
        run_op("divbig", DIV, 8'hFF, 8'h10, 9, 16'h0F0F, 1'b0, 1'b0); release_op("divbig");

        // Abort a MUL: enable sampled low at edge N+4
        opcode = MUL; a = 8'd3; b = 8'd4; enable = 1'b1;
        tick(4);
        enable = 1'b0;
        tick(1);
        chk("abort.busy", 32'(busy), 32'd0);
        for (int i = 0; i < 10; i++) begin
            chk("abort.no_done", 32'(done), 32'd0);
            tick(1);
        end
        chk("abort.result", 32'(result), 32'h0F0F);
        run_op("postabort", ADD, 8'd2, 8'd3, 2, 16'h0005, 1'b0, 1'b0); release_op("postabort");

        // Async reset in the middle of a DIV
        opcode = DIV; a = 8'd200; b = 8'd3; enable = 1'b1;
        tick(4);
        chk("rst.busy_before", 32'(busy), 32'd1);
        #2 reset = 1'b0; enable = 1'b0;
        #1;
        chk_all_zero("rst_async");
        tick(2);
        chk_all_zero("rst_hold");
        reset = 1'b1;
        tick(1);
        run_op("postrst", ADD, 8'd1, 8'd1, 2, 16'h0002, 1'b0, 1'b0);

        // Enable held after done: done and result stay put
        release_op("postrst");
        run_op("hold", ADD, 8'd7, 8'd8, 2, 16'h000F, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("hold.done", 32'(done), 32'd1);
            chk("hold.result", 32'(result), 32'h000F);
        end
        release_op("hold");
        chk("hold.result_after", 32'(result), 32'h000F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
